call_register: RTL and testbench
================================

CALL_REGISTER -- requirements
Module: call_register

Interface
REQ-001 Parameter N, default 5: number of floors; must equal the N of the elevator and elevator_controller instances.
REQ-002 Parameter DWELL_CYCLES, default 4: door-open dwell length in clk cycles; legal range 1..255.
REQ-003 clk  input  1: sole clock; all state updates on posedge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 intenral_buttons  input  N: in-car floor buttons; bit i = floor i; level signal, held for any number of cycles.
REQ-006 external_buttons  input  N: hall call buttons; same encoding.
REQ-007 current_floor  input  N: one-hot car position from elevator; bit i = car at floor i.
REQ-008 move  input  1: car moving, from elevator_controller.
REQ-009 direction  input  1: 1 = up, 0 = down; informational only, no effect on this block.
REQ-010 pending  output  N: latched outstanding requests; feeds the controller button inputs.
REQ-011 req_above / req_below  output  1 each: some pending bit above / below the current floor.
REQ-012 door_open  output  1: door open; controller shall not assert move while high.
REQ-013 protocol_err  output  1: sticky; move was seen high while door_open was high.

Function
REQ-014 Press detection: press = (intenral_buttons | external_buttons) & ~prev, where prev is the registered OR of both banks from the previous cycle.
REQ-015 A button held for K cycles yields exactly one press.
REQ-016 A press on floor i at posedge k sets pending[i] at posedge k, visible from k+1; latency 1 cycle.
REQ-017 A press on an already-pending floor has no effect.
REQ-018 FSM states: IDLE, DWELL.
REQ-019 IDLE->DWELL when all hold: move==0; current_floor one-hot; (pending | press) & current_floor != 0.
REQ-020 On that transition: door_open=1; counter=DWELL_CYCLES-1; pending bit of the current floor cleared.
REQ-021 Clear beats set when both target the same bit in the same cycle.
REQ-022 DWELL, counter>0: decrement by 1 each cycle.
REQ-023 DWELL, counter==0: go to IDLE, door_open=0; door_open is therefore high for exactly DWELL_CYCLES cycles absent extension.
REQ-024 DWELL, press on the current floor: counter reloads to DWELL_CYCLES-1; pending stays 0 for that floor.
REQ-025 DWELL, press on any other floor: pending set normally.
REQ-026 DWELL with move==1: go to IDLE, door_open=0, protocol_err=1.
REQ-027 current_floor zero or multi-hot: no service; req_above=req_below=0; pending still accepts presses.
REQ-028 req_above = OR of pending[j] for all j > index(current_floor); req_below = OR of pending[j] for all j < index; both combinational from registered pending.
REQ-029 Floor 0 has no below; floor N-1 has no above; no wrap-around.

Reset
REQ-030 Reset values: pending=0, prev=0, state=IDLE, counter=0, door_open=0, protocol_err=0.
REQ-031 Reset overrides every other event in the same cycle, including mid-dwell.
REQ-032 A button held across reset deassertion produces one press on the first cycle after reset.

Structure
REQ-033 Package elevator_pkg holds: state enum {IDLE, DWELL}; DEFAULT_FLOORS=5; DEFAULT_DWELL=4.
REQ-034 Sub-module rise_detect (parameter N) implements REQ-014; instantiated once on the OR of both button banks.
REQ-035 Counter width is 8 bits.
REQ-036 Implementation is 120-400 lines of RTL.

Verification
REQ-037 Reset, then external_buttons[0] pulsed 1 cycle with car at floor 2 moving -> pending=5'b00001 next cycle; req_below=1; req_above=0.
REQ-038 intenral_buttons[3] held 20 cycles -> pending[3] set once; release and re-press after service -> set again.
REQ-039 Car at floor 3, move=0, pending[3]=1 -> door_open high exactly 4 cycles; pending[3]=0 from first open cycle.
REQ-040 Press floor 3 on dwell cycle 3 -> door_open extended to 7 cycles total; pending[3] stays 0.
REQ-041 move=1 during dwell -> door_open=0 next cycle; protocol_err=1 until reset.
REQ-042 Reset asserted mid-dwell with pending=5'b10110 -> all outputs 0 next cycle; button held through reset -> pending set one cycle after reset release.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator call-register slice.
package elevator_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_e;

  localparam int DEFAULT_FLOORS = 5;
  localparam int DEFAULT_DWELL  = 4;
  localparam int CNT_W          = 8;
endpackage

// File: rtl/rise_detect.sv
// Per-bit rising-edge detector: one press pulse per 0->1 transition of a level.
module rise_detect #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] level_i,
  output logic [N-1:0] press_o
);
  logic [N-1:0] prev_q;

  // prev clears on reset so a level held through reset yields a press right after it.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= '0;
    else       prev_q <= level_i;
  end

  assign press_o = level_i & ~prev_q;
endmodule

// File: rtl/call_register.sv
// Latches floor calls, opens the door for a dwell period when the stopped car
// is at a called floor, and flags door/move protocol violations.
module call_register
  import elevator_pkg::*;
#(
  parameter int N            = DEFAULT_FLOORS,
  parameter int DWELL_CYCLES = DEFAULT_DWELL
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] intenral_buttons,
  input  logic [N-1:0] external_buttons,
  input  logic [N-1:0] current_floor,
  input  logic         move,
  input  logic         direction,
  output logic [N-1:0] pending,
  output logic         req_above,
  output logic         req_below,
  output logic         door_open,
  output logic         protocol_err,
  output logic         dbg_state_o
);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

  logic [N-1:0]     press;
  logic [N-1:0]     here_mask;
  logic [N-1:0]     pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  state_e           state_q, state_d;
  logic             unused_dir;

  assign unused_dir = direction;

  rise_detect #(.N(N)) u_rise (
    .clk     (clk),
    .reset   (reset),
    .level_i (intenral_buttons | external_buttons),
    .press_o (press)
  );

  // An invalid position (zero or multi-hot) selects no floor at all.
  assign here_mask = $onehot(current_floor) ? current_floor : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    pending_d = pending_q | press;
    case (state_q)
      IDLE: begin
        if (!move && |((pending_q | press) & here_mask)) begin
          state_d   = DWELL;
          cnt_d     = RELOAD;
          pending_d = (pending_q | press) & ~here_mask;
        end
      end
      DWELL: begin
        if (move) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          // A call on the floor being served extends the dwell instead of latching.
          pending_d = pending_q | (press & ~here_mask);
          if (|(press & here_mask))  cnt_d = RELOAD;
          else if (cnt_q == '0)      state_d = IDLE;
          else                       cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    req_above = 1'b0;
    req_below = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (here_mask[k]) begin
        for (int j = 0; j < N; j++) begin
          if (j > k && pending_q[j]) req_above = 1'b1;
          if (j < k && pending_q[j]) req_below = 1'b1;
        end
      end
    end
  end

  assign pending      = pending_q;
  assign door_open    = (state_q == DWELL);
  assign protocol_err = err_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_call_register.sv
// Randomised and directed stimulus for call_register, checked against a
// behavioural model through an expected-output queue.
module tb_call_register;
  localparam int N = 5;
  localparam int D = 4;
  localparam int W = N + 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] ib, eb, cf;
  logic         move, direction;
  logic [N-1:0] pending;
  logic         req_above, req_below, door_open, protocol_err, dbg_state;

  always #5 clk = ~clk;

  call_register #(.N(N), .DWELL_CYCLES(D)) dut (
    .clk              (clk),
    .reset            (reset),
    .intenral_buttons (ib),
    .external_buttons (eb),
    .current_floor    (cf),
    .move             (move),
    .direction        (direction),
    .pending          (pending),
    .req_above        (req_above),
    .req_below        (req_below),
    .door_open        (door_open),
    .protocol_err     (protocol_err),
    .dbg_state_o      (dbg_state)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  int n_checks = 0;
  int n_errors = 0;

  // Model state: calls outstanding, last button levels, open-door cycles left.
  logic [N-1:0] m_pend, m_prev;
  int           m_left;
  bit           m_err;

  function automatic int floor_of(input logic [N-1:0] v);
    int c = 0;
    int f = -1;
    for (int i = 0; i < N; i++) if (v[i]) begin c++; f = i; end
    return (c == 1) ? f : -1;
  endfunction

  task automatic drive(input logic [N-1:0] i_b, input logic [N-1:0] e_b,
                       input logic [N-1:0] c_f, input logic mv, input logic rs);
    logic [N-1:0] lvl, prs;
    int h;
    bit ab, bl;
    @(negedge clk);
    ib = i_b; eb = e_b; cf = c_f; move = mv; reset = rs;
    direction = 1'($urandom_range(0, 1));
    h = floor_of(c_f);
    if (rs) begin
      m_pend = '0; m_prev = '0; m_left = 0; m_err = 0;
    end else begin
      lvl = i_b | e_b;
      prs = lvl & ~m_prev;
      m_prev = lvl;
      if (m_left > 0) begin
        if (mv) begin
          m_err = 1; m_left = 0; m_pend |= prs;
        end else begin
          for (int i = 0; i < N; i++) if (prs[i] && i != h) m_pend[i] = 1'b1;
          if (h >= 0 && prs[h]) m_left = D;
          else m_left--;
        end
      end else begin
        m_pend |= prs;
        if (!mv && h >= 0 && m_pend[h]) begin
          m_left = D;
          m_pend[h] = 1'b0;
        end
      end
    end
    ab = 0; bl = 0;
    if (h >= 0)
      for (int j = 0; j < N; j++) if (m_pend[j]) begin
        if (j > h) ab = 1;
        if (j < h) bl = 1;
      end
    exp_q.push_back({m_pend, (m_left > 0), m_err, ab, bl});
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pending",      pending,                   e[W-1:4]);
      check("door_open",    N'(door_open),             N'(e[3]));
      check("protocol_err", N'(protocol_err),          N'(e[2]));
      check("req_above",    N'(req_above),             N'(e[1]));
      check("req_below",    N'(req_below),             N'(e[0]));
      check("dbg_state",    N'(dbg_state),             N'(e[3]));
    end
  end

  logic [N-1:0] r_ib, r_eb, r_cf;
  logic         r_mv, r_rs;

  initial begin
    ib = '0; eb = '0; cf = '0; move = 1'b0; direction = 1'b0; reset = 1'b1;
    m_pend = '0; m_prev = '0; m_left = 0; m_err = 0;
    repeat (2) drive('0, '0, 5'b00100, 1'b1, 1'b1);
    // Hall call below a moving car.
    drive('0, 5'b00001, 5'b00100, 1'b1, 1'b0);
    repeat (2) drive('0, '0, 5'b00100, 1'b1, 1'b0);
    // Held in-car button while passing floor 3, then stop and serve it.
    repeat (20) drive(5'b01000, '0, 5'b01000, 1'b1, 1'b0);
    repeat (7) drive('0, '0, 5'b01000, 1'b0, 1'b0);
    // Re-press, serve, and extend on the third open cycle.
    drive(5'b01000, '0, 5'b01000, 1'b1, 1'b0);
    repeat (3) drive('0, '0, 5'b01000, 1'b0, 1'b0);
    drive(5'b01000, '0, 5'b01000, 1'b0, 1'b0);
    repeat (8) drive('0, '0, 5'b01000, 1'b0, 1'b0);
    // Move while the door is open.
    drive('0, 5'b00010, 5'b00010, 1'b0, 1'b0);
    drive('0, '0, 5'b00010, 1'b1, 1'b0);
    repeat (3) drive('0, '0, 5'b00010, 1'b1, 1'b0);
    // Reset mid-dwell with a button held through it.
    drive('0, 5'b10110, 5'b00001, 1'b1, 1'b0);
    repeat (2) drive('0, '0, 5'b00100, 1'b0, 1'b0);
    repeat (2) drive(5'b10000, '0, 5'b00100, 1'b0, 1'b1);
    repeat (3) drive(5'b10000, '0, 5'b00100, 1'b1, 1'b0);
    drive('0, '0, 5'b00100, 1'b1, 1'b0);
    // Random traffic.
    r_ib = '0; r_eb = '0; r_cf = 5'b00001;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 9))
          8:       r_cf = '0;
          9:       r_cf = N'($urandom);
          default: r_cf = N'(1) << $urandom_range(0, N - 1);
        endcase
      end
      if ($urandom_range(0, 2) != 0) r_ib = N'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 2) != 0) r_eb = N'($urandom & $urandom & $urandom);
      r_mv = ($urandom_range(0, 5) == 0);
      r_rs = ($urandom_range(0, 80) == 0);
      drive(r_ib, r_eb, r_cf, r_mv, r_rs);
    end
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
